// File: rtl/verification_sequencer.sv
// Top-level self-check sequencer: drives operand pairs to the DUT and NUT multipliers in lockstep,
// compares their results, and reports pass/fail, mismatch counts and the first failing operands.
module verification_sequencer #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic        iIdle_dut,
  input  logic        iIdle_nut,
  input  logic        iDone_dut,
  input  logic        iDone_nut,
  input  logic [31:0] iR_dut,
  input  logic [31:0] iR_nut,
  output logic [31:0] oA,
  output logic [31:0] oB,
  output logic        oValid_Data_Flag,
  output logic        oAck_Flag,
  output logic        oBusy,
  output logic        oFinished,
  output logic        oPass,
  output logic        oTimeout,
  output logic [15:0] oError_Count,
  output logic [15:0] oVector_Count,
  output logic [31:0] oFirst_Fail_A,
  output logic [31:0] oFirst_Fail_B
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, ACK, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   lfsr;
  logic [DATA_W-1:0]   r_dut_q;
  logic [DATA_W-1:0]   r_nut_q;
  logic [TIMER_W-1:0]  timer;
  logic                done_dut_q;
  logic                done_nut_q;
  logic                done_dut_c;
  logic                done_nut_c;
  logic [DATA_W-1:0]   lfsr_step1_c;
  logic [DATA_W-1:0]   lfsr_step2_c;
  logic [CNT_W-1:0]    vec_next_c;

  // One Galois step: right shift, fold the mask in when a 1 falls out.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
  endfunction

  assign lfsr_step1_c = lfsr_next(lfsr);
  assign lfsr_step2_c = lfsr_next(lfsr_step1_c);
  assign done_dut_c   = done_dut_q | iDone_dut;
  assign done_nut_c   = done_nut_q | iDone_nut;
  assign vec_next_c   = oVector_Count + CNT_W'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= IDLE;
      lfsr             <= SEED;
      r_dut_q          <= '0;
      r_nut_q          <= '0;
      timer            <= '0;
      done_dut_q       <= 1'b0;
      done_nut_q       <= 1'b0;
      oA               <= '0;
      oB               <= '0;
      oValid_Data_Flag <= 1'b0;
      oAck_Flag        <= 1'b0;
      oBusy            <= 1'b0;
      oFinished        <= 1'b0;
      oPass            <= 1'b0;
      oTimeout         <= 1'b0;
      oError_Count     <= '0;
      oVector_Count    <= '0;
      oFirst_Fail_A    <= '0;
      oFirst_Fail_B    <= '0;
    end else begin
      oValid_Data_Flag <= 1'b0;
      oAck_Flag        <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            state         <= LOAD;
            lfsr          <= SEED;
            oBusy         <= 1'b1;
            oFinished     <= 1'b0;
            oPass         <= 1'b0;
            oTimeout      <= 1'b0;
            oError_Count  <= '0;
            oVector_Count <= '0;
            oFirst_Fail_A <= '0;
            oFirst_Fail_B <= '0;
          end
        end
        LOAD: begin
          timer      <= '0;
          done_dut_q <= 1'b0;
          done_nut_q <= 1'b0;
          if (oVector_Count == CNT_W'(0)) begin
            oA <= 32'h0000_0000;
            oB <= 32'h0000_0000;
          end else if (oVector_Count == CNT_W'(1)) begin
            oA <= 32'hFFFF_FFFF;
            oB <= 32'h0000_0001;
          end else if (oVector_Count == CNT_W'(2)) begin
            oA <= 32'h0000_0001;
            oB <= 32'hFFFF_FFFF;
          end else if (oVector_Count == CNT_W'(3)) begin
            oA <= 32'hFFFF_FFFF;
            oB <= 32'hFFFF_FFFF;
          end else begin
            oA   <= lfsr;
            oB   <= lfsr_step1_c;
            lfsr <= lfsr_step2_c;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (iIdle_dut && iIdle_nut) begin
            oValid_Data_Flag <= 1'b1;
            state            <= WAIT;
          end
        end
        // Units may finish on different cycles, so completion is tracked with sticky flags.
        WAIT: begin
          done_dut_q <= done_dut_c;
          done_nut_q <= done_nut_c;
          if (done_dut_c && done_nut_c) begin
            r_dut_q <= iR_dut;
            r_nut_q <= iR_nut;
            state   <= CHECK;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            state     <= DONE;
            oBusy     <= 1'b0;
            oTimeout  <= 1'b1;
            oFinished <= 1'b1;
            oPass     <= 1'b0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        CHECK: begin
          if (r_dut_q != r_nut_q) begin
            if (oError_Count != '1) oError_Count <= oError_Count + CNT_W'(1);
            if (oError_Count == '0) begin
              oFirst_Fail_A <= oA;
              oFirst_Fail_B <= oB;
            end
          end
          oAck_Flag <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          oVector_Count <= vec_next_c;
          done_dut_q    <= 1'b0;
          done_nut_q    <= 1'b0;
          if (vec_next_c == CNT_W'(NUM_VECTORS)) begin
            state     <= DONE;
            oBusy     <= 1'b0;
            oFinished <= 1'b1;
            oPass     <= (oError_Count == '0) && !oTimeout;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verification_sequencer.sv
// Bench for verification_sequencer: behavioural DUT/NUT multiplier stand-ins plus an operand/result
// reference model, driven by randomized latencies, idle hold-offs and injected result corruption.
module tb_verification_sequencer;

  localparam int NV = 16;
  localparam int TO = 64;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic        iIdle_dut, iIdle_nut, iDone_dut, iDone_nut;
  logic [31:0] iR_dut, iR_nut;
  logic [31:0] oA, oB, oFirst_Fail_A, oFirst_Fail_B;
  logic        oValid_Data_Flag, oAck_Flag, oBusy, oFinished, oPass, oTimeout;
  logic [15:0] oError_Count, oVector_Count;

  int checks = 0;
  int errors = 0;

  // Unit stand-ins: index 0 is the DUT, index 1 the NUT.
  logic        u_busy [2];
  logic        u_done [2];
  int          u_cnt  [2];
  logic [31:0] u_res  [2];
  int          u_hold [2];
  int          lat_tab [2][NV];
  logic [31:0] inj_tab [NV];
  bit          never_done [2];
  int          hold_cfg [2];

  int cyc = 0, valid_cnt = 0, ack_cnt = 0, proto_err = 0, ack_lat_err = 0, both_done_cyc = 0;
  int base_valid = 0, base_ack = 0, base_proto = 0, base_lat = 0;
  logic [31:0] ops_a [$];
  logic [31:0] ops_b [$];
  logic [31:0] ref_a [NV];
  logic [31:0] ref_b [NV];

  verification_sequencer #(.NUM_VECTORS(NV), .TIMEOUT(TO), .SEED(SEED)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iIdle_dut(iIdle_dut), .iIdle_nut(iIdle_nut), .iDone_dut(iDone_dut), .iDone_nut(iDone_nut),
    .iR_dut(iR_dut), .iR_nut(iR_nut), .oA(oA), .oB(oB),
    .oValid_Data_Flag(oValid_Data_Flag), .oAck_Flag(oAck_Flag), .oBusy(oBusy),
    .oFinished(oFinished), .oPass(oPass), .oTimeout(oTimeout),
    .oError_Count(oError_Count), .oVector_Count(oVector_Count),
    .oFirst_Fail_A(oFirst_Fail_A), .oFirst_Fail_B(oFirst_Fail_B)
  );

  always #5 Clock = ~Clock;

  assign iIdle_dut = !u_busy[0] && !u_done[0] && (u_hold[0] == 0);
  assign iIdle_nut = !u_busy[1] && !u_done[1] && (u_hold[1] == 0);
  assign iDone_dut = u_done[0];
  assign iDone_nut = u_done[1];
  assign iR_dut    = u_res[0];
  assign iR_nut    = u_res[1];

  // Multiplier stand-ins and handshake monitor, acting mid-cycle on the stable sequencer outputs.
  always @(negedge Clock) begin : unit_model
    logic        idle_prev [2];
    logic        both_before;
    logic [31:0] prod;
    int          vidx;
    cyc++;
    if (Reset) begin
      for (int u = 0; u < 2; u++) begin
        u_busy[u] = 1'b0; u_done[u] = 1'b0; u_cnt[u] = 0; u_res[u] = '0; u_hold[u] = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) idle_prev[u] = !u_busy[u] && !u_done[u] && (u_hold[u] == 0);
      both_before = u_done[0] && u_done[1];
      if (oAck_Flag) begin
        ack_cnt++;
        if (!(u_done[0] && u_done[1])) proto_err++;
        if (cyc - both_done_cyc != 2) ack_lat_err++;
        for (int u = 0; u < 2; u++) begin
          u_busy[u] = 1'b0; u_done[u] = 1'b0; u_hold[u] = hold_cfg[u];
        end
      end else begin
        for (int u = 0; u < 2; u++) begin
          if (u_hold[u] > 0) u_hold[u]--;
          if (u_busy[u] && !u_done[u] && !never_done[u]) begin
            if (u_cnt[u] <= 1) u_done[u] = 1'b1;
            else u_cnt[u]--;
          end
        end
        if (u_done[0] && u_done[1] && !both_before) both_done_cyc = cyc;
      end
      if (oValid_Data_Flag) begin
        vidx = (valid_cnt - base_valid) % NV;
        ops_a.push_back(oA);
        ops_b.push_back(oB);
        valid_cnt++;
        prod = oA * oB;
        for (int u = 0; u < 2; u++) begin
          if (!idle_prev[u]) proto_err++;
          u_busy[u] = 1'b1;
          u_cnt[u]  = lat_tab[u][vidx];
          u_res[u]  = (u == 0) ? (prod ^ inj_tab[vidx]) : prod;
        end
      end
    end
  end

  function automatic logic [31:0] galois(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Expected operand stream: four directed corner pairs, then consecutive LFSR states.
  function automatic void build_ref();
    logic [31:0] l = SEED;
    logic [31:0] dir_a [4] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] dir_b [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < NV; i++) begin
      if (i < 4) begin
        ref_a[i] = dir_a[i];
        ref_b[i] = dir_b[i];
      end else begin
        ref_a[i] = l; l = galois(l);
        ref_b[i] = l; l = galois(l);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_config(input int lat_lo, input int lat_hi, input int lat_nut_lo,
                            input int lat_nut_hi, input int inj_pct);
    for (int i = 0; i < NV; i++) begin
      lat_tab[0][i] = $urandom_range(lat_hi, lat_lo);
      lat_tab[1][i] = $urandom_range(lat_nut_hi, lat_nut_lo);
      inj_tab[i]    = ($urandom_range(99) < inj_pct) ? ($urandom | 32'h1) : 32'h0;
    end
  endtask

  task automatic mark_bases();
    base_valid = valid_cnt;
    base_ack   = ack_cnt;
    base_proto = proto_err;
    base_lat   = ack_lat_err;
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic run_and_wait(input int budget, output bit fin);
    int n = 0;
    mark_bases();
    pulse_start();
    while (!oFinished && n < budget) begin
      @(negedge Clock);
      n++;
    end
    fin = oFinished;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " oA"}, 64'(oA), 64'd0);
    check({tag, " oB"}, 64'(oB), 64'd0);
    check({tag, " valid"}, 64'(oValid_Data_Flag), 64'd0);
    check({tag, " ack"}, 64'(oAck_Flag), 64'd0);
    check({tag, " busy"}, 64'(oBusy), 64'd0);
    check({tag, " finished"}, 64'(oFinished), 64'd0);
    check({tag, " pass"}, 64'(oPass), 64'd0);
    check({tag, " timeout"}, 64'(oTimeout), 64'd0);
    check({tag, " err_cnt"}, 64'(oError_Count), 64'd0);
    check({tag, " vec_cnt"}, 64'(oVector_Count), 64'd0);
    check({tag, " ff_a"}, 64'(oFirst_Fail_A), 64'd0);
    check({tag, " ff_b"}, 64'(oFirst_Fail_B), 64'd0);
  endtask

  // Full-run expectations derived from the injection table and the reference operand stream.
  task automatic check_run(input string tag, input bit fin);
    int exp_err = 0;
    logic [31:0] exp_fa = '0;
    logic [31:0] exp_fb = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (inj_tab[i] != 0) begin
        exp_err++;
        exp_fa = ref_a[i];
        exp_fb = ref_b[i];
      end
    end
    check({tag, " finished"}, 64'(fin), 64'd1);
    check({tag, " valid pulses"}, 64'(valid_cnt - base_valid), 64'(NV));
    check({tag, " ack pulses"}, 64'(ack_cnt - base_ack), 64'(NV));
    check({tag, " vec_cnt"}, 64'(oVector_Count), 64'(NV));
    check({tag, " err_cnt"}, 64'(oError_Count), 64'(exp_err));
    check({tag, " pass"}, 64'(oPass), 64'(exp_err == 0));
    check({tag, " timeout"}, 64'(oTimeout), 64'd0);
    check({tag, " busy"}, 64'(oBusy), 64'd0);
    check({tag, " ff_a"}, 64'(oFirst_Fail_A), 64'(exp_fa));
    check({tag, " ff_b"}, 64'(oFirst_Fail_B), 64'(exp_fb));
    check({tag, " handshake"}, 64'(proto_err - base_proto), 64'd0);
    check({tag, " ack latency"}, 64'(ack_lat_err - base_lat), 64'd0);
    if (ops_a.size() >= base_valid + NV) begin
      for (int i = 0; i < NV; i++) begin
        check($sformatf("%s op_a[%0d]", tag, i), 64'(ops_a[base_valid + i]), 64'(ref_a[i]));
        check($sformatf("%s op_b[%0d]", tag, i), 64'(ops_b[base_valid + i]), 64'(ref_b[i]));
      end
    end
  endtask

  initial begin : stimulus
    bit fin;
    int n;
    Reset  = 1'b1;
    iStart = 1'b0;
    hold_cfg   = '{0, 0};
    never_done = '{0, 0};
    build_ref();
    set_config(3, 3, 3, 3, 0);
    repeat (3) @(negedge Clock);
    check_zero("reset");
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("idle busy", 64'(oBusy), 64'd0);

    // Matching units, fixed 3-cycle latency.
    run_and_wait(2000, fin);
    check_run("match", fin);
    check("match vec4 A is seed", 64'(ops_a[base_valid + 4]), 64'(SEED));

    // Corrupt the DUT result on vectors 5 and 9 only.
    set_config(3, 3, 3, 3, 0);
    inj_tab[5] = 32'h1;
    inj_tab[9] = 32'h1;
    run_and_wait(2000, fin);
    check_run("inject", fin);

    // Random latencies, idle hold-offs and corruption.
    for (int r = 0; r < 2; r++) begin
      set_config(1, 12, 1, 12, 25);
      hold_cfg = '{$urandom_range(3), $urandom_range(3)};
      run_and_wait(3000, fin);
      check_run($sformatf("random%0d", r), fin);
    end

    // Skewed completion with the DUT reporting busy for four ISSUE cycles.
    set_config(10, 10, 2, 2, 0);
    hold_cfg = '{6, 0};
    run_and_wait(3000, fin);
    check_run("skew", fin);
    hold_cfg = '{0, 0};

    // Reset during WAIT of vector 7, with a start pulse that must be ignored first.
    set_config(3, 3, 3, 3, 0);
    mark_bases();
    pulse_start();
    n = 0;
    while ((valid_cnt - base_valid) < 8 && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    check("abort reached vec7", 64'(valid_cnt - base_valid), 64'd8);
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    check("start ignored vec_cnt", 64'(oVector_Count), 64'd7);
    check("start ignored busy", 64'(oBusy), 64'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check_zero("midrun reset");
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("post reset idle", 64'(oBusy), 64'd0);
    run_and_wait(2000, fin);
    check_run("restart", fin);

    // DUT never finishes: abort after the WAIT budget with no Ack.
    set_config(3, 3, 3, 3, 0);
    never_done = '{1, 0};
    mark_bases();
    pulse_start();
    n = 0;
    while (!oValid_Data_Flag && n < 100) begin
      @(negedge Clock);
      n++;
    end
    n = 0;
    while (!oFinished && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check("timeout wait cycles", 64'(n), 64'(TO));
    repeat (5) @(negedge Clock);
    check("timeout flag", 64'(oTimeout), 64'd1);
    check("timeout finished", 64'(oFinished), 64'd1);
    check("timeout pass", 64'(oPass), 64'd0);
    check("timeout busy", 64'(oBusy), 64'd0);
    check("timeout vec_cnt", 64'(oVector_Count), 64'd0);
    check("timeout ack pulses", 64'(ack_cnt - base_ack), 64'd0);
    check("timeout valid pulses", 64'(valid_cnt - base_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
